// File: rtl/julia_frame_dispatcher.sv
// Raster-walks a pixel grid, issues each pixel's initial z to one Julia core and streams the escape counts out.
// Latency: 4 cycles/pixel with a minimum-latency core; pix_ready_i low holds EMIT, stalling further core starts.
module julia_frame_dispatcher #(
    parameter int INTEGER_BITS    = 8,
    parameter int FRACTIONAL_BITS = 24,
    parameter int DATA_WIDTH      = INTEGER_BITS + FRACTIONAL_BITS,
    parameter int MAX_ITER_WIDTH  = 16,
    parameter int COORD_WIDTH     = 12
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         frame_start_i,
    input  logic [COORD_WIDTH-1:0]       width_i,
    input  logic [COORD_WIDTH-1:0]       height_i,
    input  logic signed [DATA_WIDTH-1:0] x0_i,
    input  logic signed [DATA_WIDTH-1:0] y0_i,
    input  logic signed [DATA_WIDTH-1:0] step_i,
    input  logic signed [DATA_WIDTH-1:0] cx_i,
    input  logic signed [DATA_WIDTH-1:0] cy_i,
    input  logic [MAX_ITER_WIDTH-1:0]    max_iter_i,
    output logic                         core_start_o,
    output logic [DATA_WIDTH-1:0]        core_zx_o,
    output logic [DATA_WIDTH-1:0]        core_zy_o,
    output logic [DATA_WIDTH-1:0]        core_cx_o,
    output logic [DATA_WIDTH-1:0]        core_cy_o,
    output logic [MAX_ITER_WIDTH-1:0]    core_max_iter_o,
    input  logic [MAX_ITER_WIDTH-1:0]    core_iter_i,
    input  logic                         core_done_i,
    output logic                         pix_valid_o,
    input  logic                         pix_ready_i,
    output logic [MAX_ITER_WIDTH-1:0]    pix_iter_o,
    output logic [COORD_WIDTH-1:0]       pix_x_o,
    output logic [COORD_WIDTH-1:0]       pix_y_o,
    output logic                         pix_last_o,
    output logic                         busy_o,
    output logic                         frame_done_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, EMIT} state_t;

    localparam logic [COORD_WIDTH-1:0] COORD_ONE = COORD_WIDTH'(1);

    state_t                    state_q, state_d;
    logic [COORD_WIDTH-1:0]    width_q, height_q, px_q, py_q;
    logic [DATA_WIDTH-1:0]     x0_q, step_q, zx_q, zy_q, cx_q, cy_q;
    logic [MAX_ITER_WIDTH-1:0] max_iter_q, iter_q;
    logic                      frame_done_q;
    logic                      accept, empty_frame, handshake, row_end, col_end, frame_end;

    assign accept      = (state_q == IDLE) && frame_start_i;
    assign empty_frame = (width_i == '0) || (height_i == '0);
    assign handshake   = (state_q == EMIT) && pix_ready_i;
    assign row_end     = (px_q == width_q - COORD_ONE);
    assign col_end     = (py_q == height_q - COORD_ONE);
    assign frame_end   = handshake && row_end && col_end;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        core_start_o = 1'b0;
        pix_valid_o  = 1'b0;
        busy_o       = (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                if (frame_start_i && !empty_frame) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                core_start_o = 1'b1;
                state_d      = WAIT;
            end
            // done is only trusted here: the core drops it on the start edge
            WAIT: begin
                if (core_done_i) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                pix_valid_o = 1'b1;
                if (pix_ready_i) begin
                    state_d = (row_end && col_end) ? IDLE : ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            width_q      <= '0;
            height_q     <= '0;
            x0_q         <= '0;
            step_q       <= '0;
            cx_q         <= '0;
            cy_q         <= '0;
            max_iter_q   <= '0;
            px_q         <= '0;
            py_q         <= '0;
            zx_q         <= '0;
            zy_q         <= '0;
            iter_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= (accept && empty_frame) || frame_end;
            if (accept) begin
                width_q    <= width_i;
                height_q   <= height_i;
                x0_q       <= x0_i;
                step_q     <= step_i;
                cx_q       <= cx_i;
                cy_q       <= cy_i;
                max_iter_q <= max_iter_i;
                px_q       <= '0;
                py_q       <= '0;
                zx_q       <= x0_i;
                zy_q       <= y0_i;
            end
            if ((state_q == WAIT) && core_done_i) begin
                iter_q <= core_iter_i;
            end
            // imaginary axis runs downward, so each new row subtracts step
            if (handshake && !frame_end) begin
                if (!row_end) begin
                    px_q <= px_q + COORD_ONE;
                    zx_q <= zx_q + step_q;
                end else begin
                    px_q <= '0;
                    zx_q <= x0_q;
                    py_q <= py_q + COORD_ONE;
                    zy_q <= zy_q - step_q;
                end
            end
        end
    end

    assign core_zx_o       = zx_q;
    assign core_zy_o       = zy_q;
    assign core_cx_o       = cx_q;
    assign core_cy_o       = cy_q;
    assign core_max_iter_o = max_iter_q;
    assign pix_iter_o      = iter_q;
    assign pix_x_o         = px_q;
    assign pix_y_o         = py_q;
    assign pix_last_o      = (state_q == EMIT) && row_end && col_end;
    assign frame_done_o    = frame_done_q;

endmodule

// File: tb/tb_julia_frame_dispatcher.sv
// Directed bench for julia_frame_dispatcher with a behavioural Julia core that answers one cycle after start.
module tb_julia_frame_dispatcher;

    logic        clk_i = 1'b0;
    logic        rst_i, frame_start_i;
    logic [11:0] width_i, height_i;
    logic [31:0] x0_i, y0_i, step_i, cx_i, cy_i;
    logic [15:0] max_iter_i;
    logic        core_start_o;
    logic [31:0] core_zx_o, core_zy_o, core_cx_o, core_cy_o;
    logic [15:0] core_max_iter_o, core_iter_i;
    logic        core_done_i;
    logic        pix_valid_o, pix_ready_i;
    logic [15:0] pix_iter_o;
    logic [11:0] pix_x_o, pix_y_o;
    logic        pix_last_o, busy_o, frame_done_o;

    int tests_run    = 0;
    int tests_failed = 0;
    int start_cnt    = 0;

    logic        pend;
    logic [15:0] res;

    // Expected 3x2 Q8.24 frame: x0=-2, y0=1, step=1, c=0, max_iter=16
    int          ex_x[6]    = '{0, 1, 2, 0, 1, 2};
    int          ex_y[6]    = '{0, 0, 0, 1, 1, 1};
    int          ex_iter[6] = '{0, 2, 16, 1, 16, 16};
    logic [31:0] ex_zx[6]   = '{32'hFE000000, 32'hFF000000, 32'h00000000,
                                32'hFE000000, 32'hFF000000, 32'h00000000};
    logic [31:0] ex_zy[6]   = '{32'h01000000, 32'h01000000, 32'h01000000,
                                32'h00000000, 32'h00000000, 32'h00000000};

    julia_frame_dispatcher dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .frame_start_i   (frame_start_i),
        .width_i         (width_i),
        .height_i        (height_i),
        .x0_i            (x0_i),
        .y0_i            (y0_i),
        .step_i          (step_i),
        .cx_i            (cx_i),
        .cy_i            (cy_i),
        .max_iter_i      (max_iter_i),
        .core_start_o    (core_start_o),
        .core_zx_o       (core_zx_o),
        .core_zy_o       (core_zy_o),
        .core_cx_o       (core_cx_o),
        .core_cy_o       (core_cy_o),
        .core_max_iter_o (core_max_iter_o),
        .core_iter_i     (core_iter_i),
        .core_done_i     (core_done_i),
        .pix_valid_o     (pix_valid_o),
        .pix_ready_i     (pix_ready_i),
        .pix_iter_o      (pix_iter_o),
        .pix_x_o         (pix_x_o),
        .pix_y_o         (pix_y_o),
        .pix_last_o      (pix_last_o),
        .busy_o          (busy_o),
        .frame_done_o    (frame_done_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [15:0] julia(input logic signed [31:0] zx0, input logic signed [31:0] zy0,
                                          input logic signed [31:0] cx, input logic signed [31:0] cy,
                                          input logic [15:0] mx);
        longint x, y, x2, y2, lcx, lcy, four;
        logic signed [31:0] tx, ty;
        logic [15:0] n;
        x    = zx0;
        y    = zy0;
        lcx  = cx;
        lcy  = cy;
        four = longint'(4) <<< 24;
        n    = 16'd0;
        while (n < mx) begin
            x2 = (x * x) >>> 24;
            y2 = (y * y) >>> 24;
            if (x2 + y2 > four) break;
            tx = 32'(x2 - y2 + lcx);
            ty = 32'(((x * y) >>> 23) + lcy);
            x  = tx;
            y  = ty;
            n  = n + 16'd1;
        end
        return n;
    endfunction

    always @(posedge clk_i) begin
        if (rst_i) begin
            core_done_i <= 1'b0;
            core_iter_i <= 16'd0;
            pend        <= 1'b0;
            res         <= 16'd0;
        end else if (core_start_o) begin
            core_done_i <= 1'b0;
            pend        <= 1'b1;
            res         <= julia(core_zx_o, core_zy_o, core_cx_o, core_cy_o, core_max_iter_o);
            start_cnt   <= start_cnt + 1;
        end else if (pend) begin
            core_done_i <= 1'b1;
            core_iter_i <= res;
            pend        <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic setup_3x2();
        width_i    = 12'd3;
        height_i   = 12'd2;
        x0_i       = 32'hFE000000;
        y0_i       = 32'h01000000;
        step_i     = 32'h01000000;
        cx_i       = 32'h0;
        cy_i       = 32'h0;
        max_iter_i = 16'd16;
    endtask

    task automatic start_frame();
        frame_start_i = 1'b1;
        tick();
        frame_start_i = 1'b0;
        chk("busy_after_accept", busy_o, 1);
    endtask

    task automatic run_frame(input bit stall, input bit poke);
        int s_begin;
        s_begin = start_cnt;
        for (int p = 0; p < 6; p++) begin
            int b;
            b = 0;
            chk("issue", core_start_o, 1);
            while (pix_valid_o !== 1'b1 && b < 40) begin
                frame_start_i = poke;
                tick();
                frame_start_i = 1'b0;
                b++;
            end
            chk("latency", b, 3);
            chk("pix_x", pix_x_o, ex_x[p]);
            chk("pix_y", pix_y_o, ex_y[p]);
            chk("pix_iter", pix_iter_o, ex_iter[p]);
            chk("pix_last", pix_last_o, (p == 5) ? 1 : 0);
            chk("core_zx", core_zx_o, ex_zx[p]);
            chk("core_zy", core_zy_o, ex_zy[p]);
            if (stall) begin
                for (int s = 0; s < 5; s++) begin
                    tick();
                    chk("stall_valid", pix_valid_o, 1);
                    chk("stall_x", pix_x_o, ex_x[p]);
                    chk("stall_y", pix_y_o, ex_y[p]);
                    chk("stall_iter", pix_iter_o, ex_iter[p]);
                    chk("stall_last", pix_last_o, (p == 5) ? 1 : 0);
                    chk("stall_no_start", core_start_o, 0);
                end
                chk("stall_start_cnt", start_cnt - s_begin, p + 1);
            end
            pix_ready_i = 1'b1;
            tick();
            pix_ready_i = 1'b0;
        end
        chk("frame_done", frame_done_o, 1);
        chk("busy_end", busy_o, 0);
        chk("valid_end", pix_valid_o, 0);
        chk("starts_per_frame", start_cnt - s_begin, 6);
        tick();
        chk("frame_done_clear", frame_done_o, 0);
    endtask

    initial begin
        int s;
        int b;
        rst_i         = 1'b1;
        frame_start_i = 1'b0;
        pix_ready_i   = 1'b0;
        width_i       = '0;
        height_i      = '0;
        x0_i          = '0;
        y0_i          = '0;
        step_i        = '0;
        cx_i          = '0;
        cy_i          = '0;
        max_iter_i    = '0;
        repeat (3) tick();

        chk("rst_busy", busy_o, 0);
        chk("rst_start", core_start_o, 0);
        chk("rst_valid", pix_valid_o, 0);
        chk("rst_done", frame_done_o, 0);
        chk("rst_iter", pix_iter_o, 0);
        chk("rst_x", pix_x_o, 0);
        chk("rst_last", pix_last_o, 0);
        chk("rst_zx", core_zx_o, 0);
        rst_i = 1'b0;
        tick();

        // Basic frame, no backpressure
        setup_3x2();
        start_frame();
        run_frame(1'b0, 1'b0);

        // Same frame, 5-cycle stall at every pixel
        start_frame();
        run_frame(1'b1, 1'b0);

        // frame_start_i pulsed throughout the frame
        start_frame();
        run_frame(1'b0, 1'b1);
        s = start_cnt;
        repeat (3) tick();
        chk("poke_idle_busy", busy_o, 0);
        chk("poke_no_extra_start", start_cnt, s);

        // Zero-width frame
        width_i  = 12'd0;
        height_i = 12'd4;
        s = start_cnt;
        frame_start_i = 1'b1;
        tick();
        frame_start_i = 1'b0;
        chk("zero_done", frame_done_o, 1);
        chk("zero_busy", busy_o, 0);
        chk("zero_start", core_start_o, 0);
        tick();
        chk("zero_done_clear", frame_done_o, 0);
        chk("zero_busy2", busy_o, 0);
        repeat (3) tick();
        chk("zero_no_core_start", start_cnt, s);

        // Reset while waiting on pixel (1,0)
        setup_3x2();
        start_frame();
        b = 0;
        while (pix_valid_o !== 1'b1 && b < 40) begin
            tick();
            b++;
        end
        chk("rstw_first_x", pix_x_o, 0);
        pix_ready_i = 1'b1;
        tick();
        pix_ready_i = 1'b0;
        chk("rstw_issue", core_start_o, 1);
        tick();
        chk("rstw_in_wait", busy_o, 1);
        chk("rstw_x", pix_x_o, 1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("rstw_busy", busy_o, 0);
        chk("rstw_start", core_start_o, 0);
        chk("rstw_valid", pix_valid_o, 0);
        chk("rstw_done", frame_done_o, 0);
        chk("rstw_pix_x", pix_x_o, 0);
        chk("rstw_zx", core_zx_o, 0);
        chk("rstw_cx", core_max_iter_o, 0);
        repeat (3) begin
            tick();
            chk("rstw_no_done", frame_done_o, 0);
        end
        start_frame();
        run_frame(1'b0, 1'b0);

        // max_iter=0, 1x1 frame at z=0 with a non-zero c
        width_i    = 12'd1;
        height_i   = 12'd1;
        x0_i       = 32'h0;
        y0_i       = 32'h0;
        step_i     = 32'h01000000;
        cx_i       = 32'h00400000;
        cy_i       = 32'hFFC00000;
        max_iter_i = 16'd0;
        frame_start_i = 1'b1;
        tick();
        frame_start_i = 1'b0;
        chk("one_start_t", core_start_o, 1);
        tick();
        chk("one_valid_t1", pix_valid_o, 0);
        tick();
        chk("one_valid_t2", pix_valid_o, 0);
        tick();
        chk("one_valid_t3", pix_valid_o, 1);
        chk("one_iter", pix_iter_o, 0);
        chk("one_last", pix_last_o, 1);
        chk("one_cx", core_cx_o, 32'h00400000);
        chk("one_cy", core_cy_o, 32'hFFC00000);
        chk("one_max", core_max_iter_o, 0);
        pix_ready_i = 1'b1;
        tick();
        pix_ready_i = 1'b0;
        chk("one_frame_done", frame_done_o, 1);
        chk("one_busy", busy_o, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
